// File: rtl/gate_access_scheduler.sv
// Barrier servo scheduler: arbitrates entry/exit lane requests, sequences the
// barrier through open/hold/close and drives the servo PWM while tracking occupancy.
module gate_access_scheduler #(
    parameter int PWM_PERIOD   = 1000000,
    parameter int PULSE_OPEN   = 75000,
    parameter int PULSE_CLOSED = 25000,
    parameter int MOVE_FRAMES  = 25,
    parameter int HOLD_FRAMES  = 150,
    parameter int CAPACITY     = 6,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_in,
    input  logic             req_out,
    output logic             motor,
    output logic             grant_in,
    output logic             grant_out,
    output logic             reject_in,
    output logic             reject_out,
    output logic             busy,
    output logic [CNT_W-1:0] occupancy,
    output logic             full
);
    localparam int PWM_W   = $clog2(PWM_PERIOD);
    localparam int FRM_MAX = (HOLD_FRAMES > MOVE_FRAMES) ? HOLD_FRAMES : MOVE_FRAMES;
    localparam int FRM_W   = $clog2(FRM_MAX + 1);

    localparam logic [PWM_W-1:0] PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
    localparam logic [PWM_W-1:0] W_OPEN    = PWM_W'(PULSE_OPEN);
    localparam logic [PWM_W-1:0] W_CLOSED  = PWM_W'(PULSE_CLOSED);
    localparam logic [FRM_W-1:0] MOVE_LAST = FRM_W'(MOVE_FRAMES - 1);
    localparam logic [FRM_W-1:0] HOLD_LAST = FRM_W'(HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {S_IDLE, S_OPENING, S_HOLD, S_CLOSING} state_t;

    state_t             state_q, state_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
    logic [PWM_W-1:0]   width_q, width_d;
    logic [FRM_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   occupancy_q, occupancy_d;
    logic               motor_q, motor_d;
    logic               pend_in_q, pend_in_d;
    logic               pend_out_q, pend_out_d;
    logic               last_out_q, last_out_d;
    logic               grant_in_q, grant_in_d;
    logic               grant_out_q, grant_out_d;
    logic               reject_in_q, reject_in_d;
    logic               reject_out_q, reject_out_d;
    logic               busy_q, busy_d;
    logic               full_q, full_d;

    logic               tick, el_in, el_out, cand_in, cand_out;
    logic [PWM_W-1:0]   state_width, cur_width;
    logic [FRM_W-1:0]   frame_last;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        occupancy_d  = occupancy_q;
        pend_in_d    = pend_in_q;
        pend_out_d   = pend_out_q;
        last_out_d   = last_out_q;
        grant_in_d   = 1'b0;
        grant_out_d  = 1'b0;
        reject_in_d  = 1'b0;
        reject_out_d = 1'b0;

        tick      = (pwm_cnt_q == PWM_LAST);
        pwm_cnt_d = tick ? '0 : pwm_cnt_q + PWM_W'(1);

        // Width only changes at the frame start so every pulse is whole.
        state_width = (state_q == S_OPENING || state_q == S_HOLD) ? W_OPEN : W_CLOSED;
        cur_width   = (pwm_cnt_q == '0) ? state_width : width_q;
        width_d     = cur_width;
        motor_d     = (pwm_cnt_q < cur_width);

        el_in      = (occupancy_q < CAP);
        el_out     = (occupancy_q != '0);
        cand_in    = (req_in  | pend_in_q)  & el_in;
        cand_out   = (req_out | pend_out_q) & el_out;
        frame_last = (state_q == S_HOLD) ? HOLD_LAST : MOVE_LAST;

        if (state_q == S_IDLE) begin
            frame_cnt_d  = '0;
            reject_in_d  = (req_in  | pend_in_q)  & ~el_in;
            reject_out_d = (req_out | pend_out_q) & ~el_out;
            pend_in_d    = cand_in;
            pend_out_d   = cand_out;
            // On a tie the lane not served last wins; the loser stays pending.
            if (cand_in && (!cand_out || last_out_q)) begin
                grant_in_d  = 1'b1;
                occupancy_d = occupancy_q + CNT_W'(1);
                last_out_d  = 1'b0;
                pend_in_d   = 1'b0;
                state_d     = S_OPENING;
            end else if (cand_out) begin
                grant_out_d = 1'b1;
                occupancy_d = occupancy_q - CNT_W'(1);
                last_out_d  = 1'b1;
                pend_out_d  = 1'b0;
                state_d     = S_OPENING;
            end
        end else begin
            reject_in_d  = req_in  & ~el_in;
            reject_out_d = req_out & ~el_out;
            pend_in_d    = pend_in_q  | (req_in  & el_in);
            pend_out_d   = pend_out_q | (req_out & el_out);
            if (tick) begin
                if (frame_cnt_q == frame_last) begin
                    frame_cnt_d = '0;
                    case (state_q)
                        S_OPENING: state_d = S_HOLD;
                        S_HOLD:    state_d = S_CLOSING;
                        default:   state_d = S_IDLE;
                    endcase
                end else begin
                    frame_cnt_d = frame_cnt_q + FRM_W'(1);
                end
            end
        end

        busy_d = (state_d != S_IDLE);
        full_d = (occupancy_d == CAP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pwm_cnt_q    <= '0;
            width_q      <= W_CLOSED;
            frame_cnt_q  <= '0;
            occupancy_q  <= '0;
            motor_q      <= 1'b0;
            pend_in_q    <= 1'b0;
            pend_out_q   <= 1'b0;
            last_out_q   <= 1'b1;
            grant_in_q   <= 1'b0;
            grant_out_q  <= 1'b0;
            reject_in_q  <= 1'b0;
            reject_out_q <= 1'b0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwm_cnt_q    <= pwm_cnt_d;
            width_q      <= width_d;
            frame_cnt_q  <= frame_cnt_d;
            occupancy_q  <= occupancy_d;
            motor_q      <= motor_d;
            pend_in_q    <= pend_in_d;
            pend_out_q   <= pend_out_d;
            last_out_q   <= last_out_d;
            grant_in_q   <= grant_in_d;
            grant_out_q  <= grant_out_d;
            reject_in_q  <= reject_in_d;
            reject_out_q <= reject_out_d;
            busy_q       <= busy_d;
            full_q       <= full_d;
        end
    end

    assign motor      = motor_q;
    assign grant_in   = grant_in_q;
    assign grant_out  = grant_out_q;
    assign reject_in  = reject_in_q;
    assign reject_out = reject_out_q;
    assign busy       = busy_q;
    assign occupancy  = occupancy_q;
    assign full       = full_q;
endmodule
